// File: rtl/fpga_template_pkg.sv
// Shared types and widths for the sample accumulator and the ping-pong buffer
// that its output stream feeds.
package fpga_template_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1
    } accum_state_t;

    localparam int SAMPLE_WIDTH   = 36;
    localparam int DROP_CNT_WIDTH = 16;

endpackage

// File: rtl/stream_hold_reg.sv
// Single-entry valid/ready holding register. A new word loads when the slot is
// free or draining this cycle; otherwise it is dropped and counted.
module stream_hold_reg
    import fpga_template_pkg::*;
#(
    parameter int WIDTH = SAMPLE_WIDTH
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [WIDTH-1:0]          in_data_i,
    input  logic                      in_valid_i,
    output logic [WIDTH-1:0]          out_data_o,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic                      drop_o,
    output logic [DROP_CNT_WIDTH-1:0] drop_count_o
);

    logic [WIDTH-1:0]          data_reg;
    logic                      valid_reg;
    logic                      drop_reg;
    logic [DROP_CNT_WIDTH-1:0] drop_count_reg;
    logic                      load;
    logic                      drop_next;

    // The held word is replaceable when empty or when it transfers this cycle.
    assign load      = in_valid_i && (!valid_reg || out_ready_i);
    assign drop_next = in_valid_i && !load;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_reg       <= '0;
            valid_reg      <= 1'b0;
            drop_reg       <= 1'b0;
            drop_count_reg <= '0;
        end else begin
            drop_reg <= drop_next;
            if (load) begin
                data_reg  <= in_data_i;
                valid_reg <= 1'b1;
            end else if (valid_reg && out_ready_i) begin
                valid_reg <= 1'b0;
            end
            if (drop_next && (drop_count_reg != '1)) begin
                drop_count_reg <= drop_count_reg + DROP_CNT_WIDTH'(1);
            end
        end
    end

    assign out_data_o   = data_reg;
    assign out_valid_o  = valid_reg;
    assign drop_o       = drop_reg;
    assign drop_count_o = drop_count_reg;

endmodule

// File: rtl/sample_accumulator.sv
// Decimating accumulator: sums every DECIM signed samples into one word and
// offers it on a valid/ready stream towards the ping-pong buffer write port.
module sample_accumulator
    import fpga_template_pkg::*;
#(
    parameter int IN_WIDTH  = 24,
    parameter int OUT_WIDTH = SAMPLE_WIDTH,
    parameter int DECIM     = 16,
    parameter int CNT_WIDTH = (DECIM == 1) ? 1 : $clog2(DECIM)
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      enable_i,
    input  logic [IN_WIDTH-1:0]       sample_i,
    input  logic                      sample_valid_i,
    output logic [OUT_WIDTH-1:0]      out_data_o,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic                      drop_o,
    output logic [DROP_CNT_WIDTH-1:0] drop_count_o,
    output logic                      window_active_o
);

    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(DECIM - 1);

    accum_state_t           state_reg, state_next;
    logic [CNT_WIDTH-1:0]   count_reg, count_next;
    logic [OUT_WIDTH-1:0]   acc_reg, acc_next;
    logic [OUT_WIDTH-1:0]   sample_sext;
    logic [OUT_WIDTH-1:0]   sum;
    logic                   result_valid;

    assign sample_sext = {{(OUT_WIDTH - IN_WIDTH){sample_i[IN_WIDTH-1]}}, sample_i};
    // The first sample of a window overwrites the stale accumulator directly.
    assign sum = (count_reg == '0) ? sample_sext : acc_reg + sample_sext;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= IDLE;
            count_reg <= '0;
            acc_reg   <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            acc_reg   <= acc_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        count_next   = count_reg;
        acc_next     = acc_reg;
        result_valid = 1'b0;
        case (state_reg)
            IDLE: begin
                if (enable_i) begin
                    state_next = ACCUM;
                end
            end
            ACCUM: begin
                // Disable wins over a coincident sample; the partial window is lost.
                if (!enable_i) begin
                    state_next = IDLE;
                    count_next = '0;
                    acc_next   = '0;
                end else if (sample_valid_i) begin
                    acc_next = sum;
                    if (count_reg == LAST_CNT) begin
                        count_next   = '0;
                        result_valid = 1'b1;
                    end else begin
                        count_next = count_reg + CNT_WIDTH'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
                count_next = '0;
                acc_next   = '0;
            end
        endcase
    end

    assign window_active_o = (state_reg == ACCUM) && (count_reg != '0);

    stream_hold_reg #(
        .WIDTH(OUT_WIDTH)
    ) u_hold (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .in_data_i   (sum),
        .in_valid_i  (result_valid),
        .out_data_o  (out_data_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .drop_o      (drop_o),
        .drop_count_o(drop_count_o)
    );

endmodule

// File: tb/tb_sample_accumulator.sv
// Directed bench for sample_accumulator (DECIM=4) with a window-queue model
// checked every cycle plus literal expectations from the test plan.
module tb_sample_accumulator;

    localparam int IN_W  = 24;
    localparam int OUT_W = 36;
    localparam int DEC   = 4;

    logic              clk;
    logic              rst_n;
    logic              enable;
    logic [IN_W-1:0]   sample;
    logic              sample_valid;
    logic [OUT_W-1:0]  out_data;
    logic              out_valid;
    logic              out_ready;
    logic              drop;
    logic [15:0]       drop_count;
    logic              window_active;

    int total = 0;
    int bad   = 0;

    sample_accumulator #(
        .IN_WIDTH (IN_W),
        .OUT_WIDTH(OUT_W),
        .DECIM    (DEC)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .enable_i       (enable),
        .sample_i       (sample),
        .sample_valid_i (sample_valid),
        .out_data_o     (out_data),
        .out_valid_o    (out_valid),
        .out_ready_i    (out_ready),
        .drop_o         (drop),
        .drop_count_o   (drop_count),
        .window_active_o(window_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: enabled flag, queue of samples in the open window,
    // and the single downstream slot.
    bit      m_enabled;
    longint  m_window[$];
    bit      m_valid;
    longint  m_data;
    bit      m_drop;
    int      m_drop_cnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_enabled  = 1'b0;
            m_window.delete();
            m_valid    = 1'b0;
            m_data     = 0;
            m_drop     = 1'b0;
            m_drop_cnt = 0;
        end else begin
            bit     done;
            longint res;
            done = 1'b0;
            res  = 0;
            if (m_enabled && enable && sample_valid) begin
                m_window.push_back(longint'($signed(sample)));
                if (m_window.size() == DEC) begin
                    foreach (m_window[k]) res += m_window[k];
                    m_window.delete();
                    done = 1'b1;
                end
            end
            if (m_enabled && !enable) m_window.delete();
            m_enabled = enable;
            m_drop = 1'b0;
            if (done && (!m_valid || out_ready)) begin
                m_data  = res;
                m_valid = 1'b1;
            end else if (done) begin
                m_drop = 1'b1;
                if (m_drop_cnt < 65535) m_drop_cnt++;
            end else if (m_valid && out_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        check("out_valid", out_valid, m_valid);
        check("out_data", longint'($signed(out_data)), m_data);
        check("drop", drop, m_drop);
        check("drop_count", drop_count, m_drop_cnt);
        check("window_active", window_active, (m_enabled && m_window.size() != 0));
        if (out_valid && out_ready && rst_n)
            $display("xfer data=%0d t=%0t", $signed(out_data), $time);
    end

    task automatic cyc(input logic en, input logic v, input int s, input logic r);
        @(negedge clk);
        #1;
        enable       = en;
        sample_valid = v;
        sample       = s[IN_W-1:0];
        out_ready    = r;
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; sample_valid = 1'b0; sample = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_drop_count", drop_count, 0);
        check("rst_window_active", window_active, 0);
        #2 rst_n = 1'b1;

        // Samples 1..4; the sample in the first enable cycle is ignored.
        cyc(1, 1, 100, 1);
        for (int i = 1; i <= 4; i++) cyc(1, 1, i, 1);
        cyc(1, 0, 0, 1);
        check("t1_valid", out_valid, 1);
        check("t1_sum", longint'($signed(out_data)), 10);
        cyc(1, 0, 0, 1);
        check("t1_valid_one_cycle", out_valid, 0);

        // Most negative input, sign extension.
        for (int i = 0; i < 4; i++) cyc(1, 1, -8388608, 1);
        cyc(1, 0, 0, 1);
        check("t2_sum", longint'($signed(out_data)), -33554432);
        check("t2_raw", longint'(out_data), 64'h0000_000F_FE00_0000);

        // Backpressure: second window dropped, first word held.
        for (int i = 1; i <= 8; i++) cyc(1, 1, i, 0);
        cyc(1, 0, 0, 0);
        check("t3_drop", drop, 1);
        check("t3_drop_count", drop_count, 1);
        check("t3_held", longint'($signed(out_data)), 10);
        cyc(1, 0, 0, 1);
        check("t3_drop_pulse_end", drop, 0);
        check("t3_still_valid", out_valid, 1);
        cyc(1, 0, 0, 1);
        check("t3_drained", out_valid, 0);

        // Completion coinciding with a transfer.
        for (int i = 0; i < 4; i++) cyc(1, 1, 1, 0);
        for (int i = 0; i < 3; i++) cyc(1, 1, 2, 0);
        cyc(1, 1, 2, 1);
        cyc(1, 0, 0, 0);
        check("t4_valid", out_valid, 1);
        check("t4_new_word", longint'($signed(out_data)), 8);
        check("t4_no_drop", drop_count, 1);
        cyc(1, 0, 0, 1);
        cyc(1, 0, 0, 1);

        // Disable mid-window discards the partial sum.
        cyc(1, 1, 7, 1);
        cyc(1, 1, 7, 1);
        cyc(1, 0, 0, 1);
        check("t5_active", window_active, 1);
        cyc(0, 1, 9, 1);
        cyc(0, 0, 0, 1);
        check("t5_inactive", window_active, 0);
        cyc(1, 1, 50, 1);
        for (int i = 0; i < 4; i++) cyc(1, 1, 5, 1);
        cyc(1, 0, 0, 1);
        check("t5_sum", longint'($signed(out_data)), 20);

        // Asynchronous reset with a held word and an open window.
        for (int i = 0; i < 4; i++) cyc(1, 1, 3, 0);
        cyc(1, 1, 1, 0);
        cyc(1, 1, 1, 0);
        cyc(1, 0, 0, 0);
        check("t6_held", longint'($signed(out_data)), 12);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_valid", out_valid, 0);
        check("t6_rst_data", longint'(out_data), 0);
        check("t6_rst_drop_count", drop_count, 0);
        check("t6_rst_active", window_active, 0);
        enable = 1'b0; sample_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        #3 rst_n = 1'b1;
        cyc(1, 0, 0, 1);
        for (int i = 1; i <= 4; i++) cyc(1, 1, 2 * i, 1);
        cyc(1, 0, 0, 1);
        check("t6_sum", longint'($signed(out_data)), 20);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sample_accumulator.md
# sample_accumulator

Decimating accumulator that sits directly upstream of the ping-pong RAM buffer. It sums every DECIM consecutive signed input samples into one OUT_WIDTH-bit word and presents that word on a valid/ready stream. The stream connects straight to the buffer's write port (write_data_i / write_valid_i / write_ready_o). The input side has no backpressure. Results that cannot be delivered are dropped and counted.

## Interface
- IN_WIDTH, 24, input sample width (signed)
- OUT_WIDTH, 36, output word width (signed); must equal the buffer WIDTH
- DECIM, 16, samples per output word; 1 to 256
- CNT_WIDTH, $clog2(DECIM) (1 when DECIM==1), window counter width
- Constraint: IN_WIDTH + CNT_WIDTH <= OUT_WIDTH, so the sum never overflows.

Ports:
- clk_i  in  1  single clock, all logic on rising edge
- rst_ni  in  1  asynchronous, active-low reset
- enable_i  in  1  accumulation enable
- sample_i  in  IN_WIDTH  signed input sample
- sample_valid_i  in  1  sample_i valid this cycle; single-cycle strobe, no ready
- out_data_o  out  OUT_WIDTH  signed window sum
- out_valid_o  out  1  out_data_o valid
- out_ready_i  in  1  downstream accepts; driven by the buffer's write_ready_o
- drop_o  out  1  one-cycle pulse when a completed result is discarded
- drop_count_o  out  16  saturating count of dropped results
- window_active_o  out  1  high while state is ACCUM and sample count is nonzero (debug LED)

## Operation
- States (accum_state_t): IDLE, ACCUM.
  - IDLE -> ACCUM when enable_i is high.
  - ACCUM -> IDLE when enable_i is low. The partial window is discarded and the counter is cleared.
- In IDLE, samples are ignored.
- In ACCUM, each sample_valid_i cycle adds the sign-extended sample_i to the accumulator:
  - Sample with count==0: loads acc = sext(sample_i). No separate clear cycle is needed.
  - Sample with count==DECIM-1: completes the window. Result = acc + sext(sample_i), count returns to 0.
  - DECIM==1: every sample is a complete window.
- Output holding register, single entry:
  - A completed result loads the register and sets out_valid_o, if out_valid_o==0 or out_ready_i==1 that cycle.
  - Otherwise the new result is dropped: drop_o pulses, drop_count_o increments (saturates at 16'hFFFF), and the held word stays unchanged.
  - A transfer happens when out_valid_o && out_ready_i. out_valid_o clears the next cycle unless a new result loads in the same cycle.
- The held word is not affected by enable_i. A word that is already valid still drains after enable_i falls.
- Arithmetic: two's complement, sign extension to OUT_WIDTH, no rounding, no saturation needed.

## Timing
- Reset values: out_data_o=0, out_valid_o=0, drop_o=0, drop_count_o=0, window_active_o=0, state=IDLE, count=0, acc=0.
- Reset asserted mid-window or with a held word discards everything immediately (asynchronous). The first cycle after release is IDLE.
- Latency: out_valid_o rises in the cycle after the clock edge that samples the DECIM-th sample_valid_i.
- The enable_i rising edge is registered: samples in the first cycle with enable_i high are ignored (state still IDLE).
- A sample on the same cycle enable_i falls is ignored. Leaving ACCUM takes priority.
- Simultaneous completion, out_valid_o=1 and out_ready_i=1: the old word transfers, the new word loads, out_valid_o stays 1, no drop.
- Throughput: up to one word per cycle (DECIM==1 with out_ready_i held high).

## Structure
- Shared package fpga_template_pkg holds:
  - accum_state_t (2-bit enum: IDLE, ACCUM)
  - SAMPLE_WIDTH = 36, shared with the buffer's WIDTH
  - DROP_CNT_WIDTH = 16
- One sub-module, stream_hold_reg: a single-entry valid/ready register with a load-or-drop indication. The accumulator and FSM stay in the top module.

## Test plan
- DECIM=4, enable_i=1, samples 1,2,3,4 with out_ready_i=1 -> out_data_o=10, out_valid_o high for exactly 1 cycle, the cycle after sample 4.
- DECIM=4, four samples of -8388608 -> out_data_o = -33554432, correctly sign-extended to 36 bits.
- out_ready_i=0, two complete windows -> first word held; drop_o pulses once at the second completion; drop_count_o=1. Raising out_ready_i then transfers the first word.
- Held word valid, out_ready_i=1 in the same cycle a new window completes -> old word transferred, new word loaded, drop_count_o stays 0.
- enable_i dropped after 2 of 4 samples, then re-enabled, then samples 5,5,5,5 -> out_data_o=20 (partial sum discarded).
- rst_ni pulsed low asynchronously mid-window with a held word -> all outputs zero immediately; the next full window produces the correct sum.
